fitness_collect_unit: RTL and testbench
=======================================

Name: fitness_collect_unit

Overview:
- Consumes the per-individual energy stream from the fitness evaluation stage and writes each energy into a POP_SIZE-entry fitness register file, indexed by arrival order.
- Tracks the minimum-energy (best) individual of the current generation.
- Declares the generation complete and exposes a 1-cycle-latency read port to the downstream selection stage.

Parameters:
- SELF_FIT_LENGTH, 10, width of one total-energy value
- POP_SIZE, 50, individuals per generation (≥1)
- ADDR_WIDTH, 6, fitness RF address width (2^ADDR_WIDTH ≥ POP_SIZE)

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid_i  in  1  energy_i valid (driven by evaluator out_valid)
- energy_i  in  SELF_FIT_LENGTH  unsigned total energy of the current individual
- done_i  in  1  evaluator generation-end pulse
- ind_idx_i  in  1  evaluator individual-buffer tag
- clear_i  in  1  start new generation; synchronous, 1-cycle pulse
- rd_en_i  in  1  read request
- rd_addr_i  in  ADDR_WIDTH  read address
- rd_data_ff_o  out  SELF_FIT_LENGTH  registered read data
- rd_valid_ff_o  out  1  rd_data valid
- best_energy_ff_o  out  SELF_FIT_LENGTH  minimum energy so far
- best_idx_ff_o  out  ADDR_WIDTH  index of best individual
- count_ff_o  out  ADDR_WIDTH+1  accepted writes this generation
- gen_tag_ff_o  out  1  ind_idx_i latched at first write of the generation
- pop_ready_ff_o  out  1  generation complete; RF stable for reading
- overflow_ff_o  out  1  sticky: write attempted while READY

Behaviour:
- Reset values of all outputs:
  - best_energy_ff_o = all ones.
  - All other outputs = 0.
  - FSM = IDLE; wr_ptr = 0.
  - RF contents are cleared to 0.
- FSM states: IDLE, COLLECT, READY.
- IDLE:
  - in_valid_i writes energy_i to RF[0]; wr_ptr becomes 1; gen_tag latched.
  - Next state is COLLECT.
  - Next state is READY instead if POP_SIZE==1 or done_i is asserted in the same cycle.
- COLLECT, on in_valid_i:
  - Write energy_i to RF[wr_ptr]; wr_ptr and count increment.
  - Go to READY when wr_ptr+1 == POP_SIZE.
- COLLECT, on done_i:
  - Go to READY (short generation), whether or not in_valid_i is present.
  - A write in the same cycle as done_i is accepted first.
- READY:
  - Writes are dropped; overflow_ff_o sets and stays set until clear_i or reset.
  - done_i is ignored.
- clear_i, any state:
  - Next state IDLE; wr_ptr/count = 0.
  - best_energy = all ones; best_idx = 0; overflow = 0; pop_ready = 0.
  - RF contents are not cleared.
  - clear_i has priority over a simultaneous in_valid_i; that write is lost.
- Write timing: RF, count and best update on the clock edge that samples in_valid_i. No backpressure: every valid in IDLE/COLLECT is accepted.
- Best tracking:
  - Update when energy_i < best_energy (strict, unsigned).
  - On ties the earlier (lower) index is kept.
  - best_idx = the write address used.
- pop_ready_ff_o: high exactly while state==READY, asserted the cycle after the completing write.
- Read port:
  - rd_en_i at cycle N gives rd_data_ff_o = RF[rd_addr_i] and rd_valid_ff_o = 1 at N+1.
  - rd_valid_ff_o = 0 otherwise; rd_data_ff_o holds its last value.
  - Reads are legal in any state.
  - Same-cycle read and write to the same address returns the old data.
  - rd_addr_i ≥ POP_SIZE returns 0 with rd_valid_ff_o = 1.
- Width rules: energies stored unmodified; count is ADDR_WIDTH+1 bits so POP_SIZE is representable.
- Reset mid-operation: all state returns to reset values immediately (async); no partial-generation state survives.

Test Plan:
- Reset, then 50 valids with energy = 100-i (i=0..49) → pop_ready=1 one cycle after the 50th; count=50; best_energy=51; best_idx=49; overflow=0.
- Energies 20,7,7,30 with POP_SIZE=4 → best_energy=7, best_idx=1 (tie keeps the earlier index); read addr 3 → rd_data=30 one cycle later with rd_valid=1.
- 10 valids, then done_i together with the 11th valid (energy 5) → READY; count=11; best_energy=5; best_idx=10.
- In READY, apply a further valid with energy 1 → overflow=1; best and count unchanged. Then clear_i → IDLE, overflow=0, best_energy=1023, count=0.
- clear_i and in_valid_i (energy 3) in the same cycle during COLLECT → count=0, best=1023, write dropped; the next valid goes to addr 0.
- Assert rst_n=0 asynchronously mid-COLLECT (count=25) → all outputs at reset values before the next clock edge; state IDLE.

Source files
------------

// File: rtl/fitness_collect_unit.sv
// rtl/fitness_collect_unit.sv - collects per-individual energies into a fitness RF and tracks the best individual
module fitness_collect_unit #(
    parameter int SELF_FIT_LENGTH = 10,
    parameter int POP_SIZE        = 50,
    parameter int ADDR_WIDTH      = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0] energy_i,
    input  logic                       done_i,
    input  logic                       ind_idx_i,
    input  logic                       clear_i,
    input  logic                       rd_en_i,
    input  logic [ADDR_WIDTH-1:0]      rd_addr_i,
    output logic [SELF_FIT_LENGTH-1:0] rd_data_ff_o,
    output logic                       rd_valid_ff_o,
    output logic [SELF_FIT_LENGTH-1:0] best_energy_ff_o,
    output logic [ADDR_WIDTH-1:0]      best_idx_ff_o,
    output logic [ADDR_WIDTH:0]        count_ff_o,
    output logic                       gen_tag_ff_o,
    output logic                       pop_ready_ff_o,
    output logic                       overflow_ff_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_READY   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] L_POP = (ADDR_WIDTH+1)'(POP_SIZE);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [SELF_FIT_LENGTH-1:0] r_rf [POP_SIZE];
    logic [ADDR_WIDTH:0]        r_count;
    logic [SELF_FIT_LENGTH-1:0] r_best_energy;
    logic [ADDR_WIDTH-1:0]      r_best_idx;
    logic                       r_gen_tag;
    logic                       r_overflow;
    logic [SELF_FIT_LENGTH-1:0] r_rd_data;
    logic                       r_rd_valid;

    logic                       w_wr_en;
    logic                       w_ovf_set;
    logic [ADDR_WIDTH-1:0]      w_wr_addr;
    logic [ADDR_WIDTH:0]        w_count_inc;
    logic                       w_rd_in_range;

    // The write pointer always equals the accepted-write count.
    assign w_wr_addr     = r_count[ADDR_WIDTH-1:0];
    assign w_count_inc   = r_count + 1'b1;
    assign w_rd_in_range = ({1'b0, rd_addr_i} < L_POP);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_ovf_set   = 1'b0;
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        w_wr_en     = 1'b1;
                        w_state_nxt = (done_i || w_count_inc == L_POP) ? S_READY : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    w_wr_en = in_valid_i;
                    if (done_i || (in_valid_i && w_count_inc == L_POP)) begin
                        w_state_nxt = S_READY;
                    end
                end
                S_READY: begin
                    w_ovf_set = in_valid_i;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_best_energy <= '1;
            r_best_idx    <= '0;
            r_gen_tag     <= 1'b0;
            r_overflow    <= 1'b0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            for (int i = 0; i < POP_SIZE; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= rd_en_i;
            // Non-blocking read sees pre-write contents on a same-cycle collision.
            if (rd_en_i) begin
                r_rd_data <= w_rd_in_range ? r_rf[rd_addr_i] : '0;
            end
            if (clear_i) begin
                r_count       <= '0;
                r_best_energy <= '1;
                r_best_idx    <= '0;
                r_overflow    <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_rf[w_wr_addr] <= energy_i;
                    r_count         <= w_count_inc;
                    if (r_state == S_IDLE) begin
                        r_gen_tag <= ind_idx_i;
                    end
                    if (energy_i < r_best_energy) begin
                        r_best_energy <= energy_i;
                        r_best_idx    <= w_wr_addr;
                    end
                end
                if (w_ovf_set) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign rd_data_ff_o     = r_rd_data;
    assign rd_valid_ff_o    = r_rd_valid;
    assign best_energy_ff_o = r_best_energy;
    assign best_idx_ff_o    = r_best_idx;
    assign count_ff_o       = r_count;
    assign gen_tag_ff_o     = r_gen_tag;
    assign pop_ready_ff_o   = (r_state == S_READY);
    assign overflow_ff_o    = r_overflow;

endmodule

// File: tb/tb_fitness_collect_unit.sv
// tb/tb_fitness_collect_unit.sv - scoreboard bench for fitness_collect_unit (POP_SIZE 50 and 4)
module tb_fitness_collect_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 0, done = 0, ind_idx = 0, clear = 0, rd_en = 0;
    logic [9:0] energy = '0;
    logic [5:0] rd_addr = '0;
    logic [9:0] rd_data, best_e;
    logic [5:0] best_idx;
    logic [6:0] count;
    logic       rd_valid, gen_tag, pop_ready, overflow;

    logic       in_valid4 = 0, done4 = 0, clear4 = 0, rd_en4 = 0;
    logic [9:0] energy4 = '0;
    logic [1:0] rd_addr4 = '0;
    logic [9:0] rd_data4, best_e4;
    logic [1:0] best_idx4;
    logic [2:0] count4;
    logic       rd_valid4, gen_tag4, pop_ready4, overflow4;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [9:0] q[$];
    logic [9:0] q4[$];
    logic [9:0] e_exp, e_exp4;

    always #5 clk = ~clk;

    fitness_collect_unit #(.SELF_FIT_LENGTH(10), .POP_SIZE(50), .ADDR_WIDTH(6)) dut (
        .clk_i(clk), .rst_n(rst_n), .in_valid_i(in_valid), .energy_i(energy), .done_i(done),
        .ind_idx_i(ind_idx), .clear_i(clear), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_ff_o(rd_data), .rd_valid_ff_o(rd_valid), .best_energy_ff_o(best_e),
        .best_idx_ff_o(best_idx), .count_ff_o(count), .gen_tag_ff_o(gen_tag),
        .pop_ready_ff_o(pop_ready), .overflow_ff_o(overflow)
    );

    fitness_collect_unit #(.SELF_FIT_LENGTH(10), .POP_SIZE(4), .ADDR_WIDTH(2)) dut4 (
        .clk_i(clk), .rst_n(rst_n), .in_valid_i(in_valid4), .energy_i(energy4), .done_i(done4),
        .ind_idx_i(1'b0), .clear_i(clear4), .rd_en_i(rd_en4), .rd_addr_i(rd_addr4),
        .rd_data_ff_o(rd_data4), .rd_valid_ff_o(rd_valid4), .best_energy_ff_o(best_e4),
        .best_idx_ff_o(best_idx4), .count_ff_o(count4), .gen_tag_ff_o(gen_tag4),
        .pop_ready_ff_o(pop_ready4), .overflow_ff_o(overflow4)
    );

    // Read-data monitors: pop one expected value per presented rd_valid.
    always @(negedge clk) begin
        if (rd_valid) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got data=%0d, expected no read response", rd_data);
            end else begin
                e_exp = q.pop_front();
                if (rd_data !== e_exp) begin
                    n_fail++;
                    $display("FAIL rd_data: got %0d, expected %0d", rd_data, e_exp);
                end
            end
        end
        if (rd_valid4) begin
            n_tests++;
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL rd4_unexpected: got data=%0d, expected no read response", rd_data4);
            end else begin
                e_exp4 = q4.pop_front();
                if (rd_data4 !== e_exp4) begin
                    n_fail++;
                    $display("FAIL rd4_data: got %0d, expected %0d", rd_data4, e_exp4);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_st(input string name, input int cnt, input int be, input int bi,
                          input int pr, input int ovf);
        chk({name, ".count"}, int'(count), cnt);
        chk({name, ".best_energy"}, int'(best_e), be);
        chk({name, ".best_idx"}, int'(best_idx), bi);
        chk({name, ".pop_ready"}, int'(pop_ready), pr);
        chk({name, ".overflow"}, int'(overflow), ovf);
    endtask

    task automatic drive(input logic v, input logic [9:0] e, input logic d, input logic c,
                         input logic re, input logic [5:0] a, input logic [9:0] exp);
        @(negedge clk);
        in_valid = v; energy = e; done = d; clear = c; rd_en = re; rd_addr = a;
        if (re) q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 0; done = 0; clear = 0; rd_en = 0;
    endtask

    task automatic drive4(input logic v, input logic [9:0] e, input logic d, input logic c,
                          input logic re, input logic [1:0] a, input logic [9:0] exp);
        @(negedge clk);
        in_valid4 = v; energy4 = e; done4 = d; clear4 = c; rd_en4 = re; rd_addr4 = a;
        if (re) q4.push_back(exp);
        @(posedge clk);
        #1;
        in_valid4 = 0; done4 = 0; clear4 = 0; rd_en4 = 0;
    endtask

    task automatic wr(input logic [9:0] e);
        drive(1'b1, e, 1'b0, 1'b0, 1'b0, 6'd0, 10'd0);
    endtask

    task automatic rd(input logic [5:0] a, input logic [9:0] exp);
        drive(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, a, exp);
    endtask

    task automatic clr();
        drive(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 6'd0, 10'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_st("reset", 0, 1023, 0, 0, 0);
        chk("reset.gen_tag", int'(gen_tag), 0);
        chk("reset.rd_valid", int'(rd_valid), 0);
        rd(6'd5, 10'd0);

        // Full generation, descending energies
        for (int i = 0; i < 50; i++) begin
            wr(10'(100 - i));
            if (i == 48) chk_st("full49", 49, 52, 48, 0, 0);
        end
        chk_st("full50", 50, 51, 49, 1, 0);
        chk("full50.gen_tag", int'(gen_tag), 0);
        rd(6'd0, 10'd100);
        rd(6'd49, 10'd51);
        rd(6'd50, 10'd0);
        rd(6'd63, 10'd0);

        // Writes in READY set overflow; done ignored
        wr(10'd1);
        chk_st("ovf_a", 50, 51, 49, 1, 1);
        drive(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0);
        chk_st("ready_done", 50, 51, 49, 1, 1);
        clr();
        chk_st("clear_a", 0, 1023, 0, 0, 0);

        // Short generation; RF survives clear; same-cycle read/write returns old data
        ind_idx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) drive(1'b1, 10'(200 + i), 1'b0, 1'b0, 1'b1, 6'd3, 10'd97);
            else        wr(10'(200 + i));
            ind_idx = 1'b0;
        end
        chk("short.gen_tag", int'(gen_tag), 1);
        chk_st("short10", 10, 200, 0, 0, 0);
        drive(1'b1, 10'd5, 1'b1, 1'b0, 1'b0, 6'd0, 10'd0);
        chk_st("short11", 11, 5, 10, 1, 0);
        rd(6'd10, 10'd5);
        rd(6'd3, 10'd203);
        wr(10'd1);
        chk_st("ovf_b", 11, 5, 10, 1, 1);
        clr();
        chk_st("clear_b", 0, 1023, 0, 0, 0);

        // clear beats a simultaneous write
        wr(10'd40);
        chk("gen0.gen_tag", int'(gen_tag), 0);
        ind_idx = 1'b1;
        wr(10'd50);
        chk("gen_keep.gen_tag", int'(gen_tag), 0);
        chk_st("pre_clr", 2, 40, 0, 0, 0);
        drive(1'b1, 10'd3, 1'b0, 1'b1, 1'b0, 6'd0, 10'd0);
        chk_st("clr_wr", 0, 1023, 0, 0, 0);
        wr(10'd9);
        ind_idx = 1'b0;
        chk_st("after_clr", 1, 9, 0, 0, 0);
        chk("after_clr.gen_tag", int'(gen_tag), 1);
        rd(6'd0, 10'd9);

        // Asynchronous reset mid-COLLECT
        for (int i = 0; i < 24; i++) wr(10'(300 + i));
        chk_st("pre_rst", 25, 9, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_st("async_rst", 0, 1023, 0, 0, 0);
        chk("async_rst.gen_tag", int'(gen_tag), 0);
        chk("async_rst.rd_data", int'(rd_data), 0);
        chk("async_rst.rd_valid", int'(rd_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(6'd0, 10'd0);
        wr(10'd77);
        chk_st("post_rst", 1, 77, 0, 0, 0);

        // POP_SIZE = 4 instance
        drive4(1'b1, 10'd20, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        drive4(1'b1, 10'd7,  1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        drive4(1'b1, 10'd7,  1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        chk("p4_3.pop_ready", int'(pop_ready4), 0);
        drive4(1'b1, 10'd30, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0);
        chk("p4_4.pop_ready", int'(pop_ready4), 1);
        chk("p4_4.count", int'(count4), 4);
        chk("p4_4.best_energy", int'(best_e4), 7);
        chk("p4_4.best_idx", int'(best_idx4), 1);
        chk("p4_4.overflow", int'(overflow4), 0);
        drive4(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd3, 10'd30);
        drive4(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd1, 10'd7);
        drive4(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 2'd0, 10'd0);
        chk("p4_clr.pop_ready", int'(pop_ready4), 0);
        drive4(1'b1, 10'd12, 1'b1, 1'b0, 1'b0, 2'd0, 10'd0);
        chk("p4_idle_done.pop_ready", int'(pop_ready4), 1);
        chk("p4_idle_done.count", int'(count4), 1);
        chk("p4_idle_done.best_energy", int'(best_e4), 12);

        repeat (3) @(negedge clk);
        #1;
        chk("rd_queue_drained", q.size(), 0);
        chk("rd4_queue_drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
